// File: rtl/seq_muldiv_if.sv
// Start/busy/done request bus between the EX stage and the multi-cycle mul/div unit.
// master = CPU side (drives start/op/a/b), slave = unit side (drives results and status).
interface seq_muldiv_if #(
   parameter int WIDTH = 32
);
   // Handshake: start is sampled only while the unit is idle; the operation is accepted
   // on that edge, busy is high from the next cycle, and done pulses for exactly one
   // cycle with hi/lo/div_zero valid. start seen while busy or in DONE is dropped.
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_zero;

   modport master (output start, op, a, b, input busy, done, hi, lo, div_zero);
   modport slave  (input start, op, a, b, output busy, done, hi, lo, div_zero);
endinterface

// File: rtl/seq_muldiv_unit.sv
// Iterative signed/unsigned multiply and restoring divide, one bit per cycle,
// producing a HI/LO pair (product halves, or remainder/quotient).
module seq_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         rstn,
   seq_muldiv_if.slave  bus,
   output logic [1:0]   o_dbg_state
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t             r_state;
   logic [CW-1:0]      r_cnt;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic [WIDTH-1:0]   r_mb;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH:0]     r_rem;
   logic [WIDTH-1:0]   r_res_hi;
   logic [WIDTH-1:0]   r_res_lo;
   logic               r_res_dz;
   logic               r_busy;
   logic               r_done;
   logic               r_dz;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;

   logic               w_signed;
   logic               w_is_div;
   logic [WIDTH-1:0]   w_abs_a;
   logic [WIDTH-1:0]   w_abs_b;
   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH:0]     w_mul_sum;
   logic [WIDTH:0]     w_shift;
   logic [WIDTH:0]     w_diff;
   logic [2*WIDTH-1:0] w_prod_fix;
   logic [WIDTH-1:0]   w_quo_fix;
   logic [WIDTH-1:0]   w_rem_fix;

   assign w_signed = ~bus.op[0];
   assign w_is_div = bus.op[1];
   // Magnitudes stay unsigned in WIDTH bits, so -2^(W-1) maps to 2^(W-1) without overflow.
   assign w_abs_a  = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_abs_b  = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // Multiply: multiplier sits in acc[W-1:0] and is shifted out LSB-first.
   assign w_addend  = r_acc[0] ? r_mb : {WIDTH{1'b0}};
   assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

   // Divide: dividend bits shift out of acc[W-1] into the remainder, quotient bits shift in.
   assign w_shift = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
   assign w_diff  = w_shift - {1'b0, r_mb};

   assign w_prod_fix = r_neg_q ? -r_acc : r_acc;
   assign w_quo_fix  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem_fix  = r_neg_r ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_mb     <= '0;
         r_acc    <= '0;
         r_rem    <= '0;
         r_res_hi <= '0;
         r_res_lo <= '0;
         r_res_dz <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_dz     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done <= 1'b0;
               if (bus.start) begin
                  r_is_div <= w_is_div;
                  r_busy   <= 1'b1;
                  r_cnt    <= CW'(WIDTH);
                  r_rem    <= '0;
                  if (w_is_div) begin
                     r_mb    <= w_abs_b;
                     r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                     r_neg_q <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     r_neg_r <= w_signed & bus.a[WIDTH-1];
                     if (bus.b == '0) begin
                        r_res_hi <= bus.a;
                        r_res_lo <= '1;
                        r_res_dz <= 1'b1;
                        r_state  <= S_DONE;
                     end else begin
                        r_res_dz <= 1'b0;
                        r_state  <= S_CALC;
                     end
                  end else begin
                     r_mb     <= w_abs_a;
                     r_acc    <= {{WIDTH{1'b0}}, w_abs_b};
                     r_neg_q  <= w_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                     r_neg_r  <= 1'b0;
                     r_res_dz <= 1'b0;
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt - CW'(1);
               if (r_is_div) begin
                  r_rem            <= w_diff[WIDTH] ? w_shift : w_diff;
                  r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], ~w_diff[WIDTH]};
               end else begin
                  r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
               end
               if (r_cnt == CW'(1)) r_state <= S_FIX;
            end
            S_FIX: begin
               if (r_is_div) begin
                  r_res_hi <= w_rem_fix;
                  r_res_lo <= w_quo_fix;
               end else begin
                  {r_res_hi, r_res_lo} <= w_prod_fix;
               end
               r_busy  <= 1'b0;
               r_state <= S_DONE;
            end
            S_DONE: begin
               r_hi    <= r_res_hi;
               r_lo    <= r_res_lo;
               r_dz    <= r_res_dz;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy     = r_busy;
   assign bus.done     = r_done;
   assign bus.hi       = r_hi;
   assign bus.lo       = r_lo;
   assign bus.div_zero = r_dz;
   assign o_dbg_state  = r_state;
endmodule
